// File: rtl/jtbubl_sndmix.sv
// rtl/jtbubl_sndmix.sv - stereo-to-mono mixer with ramped gain, mute fade, saturation and clip counter
module jtbubl_sndmix #(
    parameter int         RAMP_STEP = 1,
    parameter logic [7:0] UNITY     = 8'h40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_in,
    input  logic signed [15:0] left,
    input  logic signed [15:0] right,
    input  logic [1:0]        fxlevel,
    input  logic              mute,
    input  logic              clr_clip,
    output logic signed [15:0] snd,
    output logic              sample_out,
    output logic [7:0]        clip_cnt
);

    localparam logic [7:0]         STEP    = 8'(RAMP_STEP);
    localparam logic signed [18:0] POS_MAX = 19'sd32767;
    localparam logic signed [18:0] NEG_MIN = -19'sd32768;

    logic [7:0]         cur_gain;
    logic [7:0]         target;
    logic [7:0]         diff;
    logic [7:0]         step;
    logic [7:0]         next_gain;

    logic               v1, v2;
    logic signed [16:0] sum1;
    logic [7:0]         g1;
    logic signed [25:0] prod2;
    logic signed [18:0] m;
    logic               clip_pos, clip_neg, clip;

    // UNITY only names the Q2.6 scale; the table below is fixed in absolute codes
    always_comb begin
        target = 8'h00;
        if (!mute) begin
            case (fxlevel)
                2'd0:    target = 8'h20;
                2'd1:    target = 8'h40;
                2'd2:    target = 8'h60;
                default: target = 8'h80;
            endcase
        end
    end

    always_comb begin
        diff      = 8'h00;
        step      = 8'h00;
        next_gain = cur_gain;
        if (cur_gain < target) begin
            diff      = target - cur_gain;
            step      = (diff < STEP) ? diff : STEP;
            next_gain = cur_gain + step;
        end else if (cur_gain > target) begin
            diff      = cur_gain - target;
            step      = (diff < STEP) ? diff : STEP;
            next_gain = cur_gain - step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_gain <= 8'h00;
        end else if (sample_in) begin
            cur_gain <= next_gain;
        end
    end

    // S1: sum and the gain in force before this sample's ramp step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            sum1 <= '0;
            g1   <= 8'h00;
        end else begin
            v1 <= sample_in;
            if (sample_in) begin
                sum1 <= 17'(left) + 17'(right);
                g1   <= cur_gain;
            end
        end
    end

    // S2: sum x gain; gain is zero-extended so it stays non-negative
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            prod2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                prod2 <= sum1 * $signed({1'b0, g1});
            end
        end
    end

    // >>>7 folds the /2 average and the /64 gain scale into one shift
    assign m        = prod2[25:7];
    assign clip_pos = (m > POS_MAX);
    assign clip_neg = (m < NEG_MIN);
    assign clip     = v2 && (clip_pos || clip_neg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd        <= '0;
            sample_out <= 1'b0;
        end else begin
            sample_out <= v2;
            if (v2) begin
                if (clip_pos) begin
                    snd <= 16'sh7FFF;
                end else if (clip_neg) begin
                    snd <= -16'sh8000;
                end else begin
                    snd <= m[15:0];
                end
            end
        end
    end

    // a clear coinciding with a clip still records that clip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= 8'h00;
        end else if (clr_clip) begin
            clip_cnt <= clip ? 8'h01 : 8'h00;
        end else if (clip && clip_cnt != 8'hFF) begin
            clip_cnt <= clip_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_jtbubl_sndmix.sv
// tb/tb_jtbubl_sndmix.sv - directed self-checking bench for jtbubl_sndmix
module tb_jtbubl_sndmix;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_in = 1'b0;
    logic [15:0] left = '0;
    logic [15:0] right = '0;
    logic [1:0]  fxlevel = 2'd1;
    logic        mute = 1'b0;
    logic        clr_clip = 1'b0;
    logic [15:0] snd;
    logic        sample_out;
    logic [7:0]  clip_cnt;

    int tests = 0;
    int fails = 0;

    jtbubl_sndmix dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_in  (sample_in),
        .left       (left),
        .right      (right),
        .fxlevel    (fxlevel),
        .mute       (mute),
        .clr_clip   (clr_clip),
        .snd        (snd),
        .sample_out (sample_out),
        .clip_cnt   (clip_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // strobe one sample, then advance to the edge where its result appears
    task automatic pulse(input logic [15:0] l, input logic [15:0] r);
        left      = l;
        right     = r;
        sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic sample_chk(input string tag, input logic [15:0] l, input logic [15:0] r,
                              input logic [15:0] exp, input int gap);
        pulse(l, r);
        chk({tag, "_strobe"}, {15'b0, sample_out}, 16'h0001);
        chk(tag, snd, exp);
        repeat (gap) tick();
    endtask

    logic seen;

    initial begin
        #3;
        chk("reset_snd", snd, 16'h0000);
        chk("reset_strobe", {15'b0, sample_out}, 16'h0000);
        chk("reset_clip", {8'h00, clip_cnt}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        // fade-in at unity target
        fxlevel = 2'd1;
        for (int k = 0; k <= 67; k++) begin
            sample_chk("fade_in", 16'h1000, 16'h1000, (k <= 64) ? 16'(k * 16'h0040) : 16'h1000, 497);
        end

        // mute fade-out, then back up
        mute = 1'b1;
        for (int k = 0; k <= 66; k++) begin
            sample_chk("mute_down", 16'h1000, 16'h1000, (k <= 64) ? 16'(16'h1000 - k * 16'h0040) : 16'h0000, 1);
        end
        mute = 1'b0;
        for (int k = 0; k <= 65; k++) begin
            sample_chk("mute_up", 16'h1000, 16'h1000, (k <= 64) ? 16'(k * 16'h0040) : 16'h1000, 1);
        end

        // back-to-back strobes at unity gain
        left = 16'h0100; right = 16'h0100; sample_in = 1'b1;
        tick();
        left = 16'h0200; right = 16'h0200;
        tick();
        chk("tp_early", {15'b0, sample_out}, 16'h0000);
        left = 16'h0300; right = 16'h0300;
        tick();
        sample_in = 1'b0;
        chk("tp_s0", {15'b0, sample_out}, 16'h0001);
        chk("tp_d0", snd, 16'h0100);
        tick();
        chk("tp_s1", {15'b0, sample_out}, 16'h0001);
        chk("tp_d1", snd, 16'h0200);
        tick();
        chk("tp_s2", {15'b0, sample_out}, 16'h0001);
        chk("tp_d2", snd, 16'h0300);
        tick();
        chk("tp_end", {15'b0, sample_out}, 16'h0000);
        chk("tp_hold", snd, 16'h0300);

        // ramp silently from 0x40 to 0x80
        fxlevel = 2'd3;
        for (int k = 0; k < 64; k++) pulse(16'h0000, 16'h0000);
        chk("clip_pre", {8'h00, clip_cnt}, 16'h0000);

        sample_chk("sat_pos0", 16'h7000, 16'h7000, 16'h7FFF, 1);
        chk("clip_1", {8'h00, clip_cnt}, 16'h0001);
        sample_chk("sat_pos1", 16'h7000, 16'h7000, 16'h7FFF, 1);
        chk("clip_2", {8'h00, clip_cnt}, 16'h0002);
        sample_chk("sat_neg", 16'h9000, 16'h9000, 16'h8000, 1);
        chk("clip_3", {8'h00, clip_cnt}, 16'h0003);
        sample_chk("mixed", 16'h7000, 16'h9000, 16'h0000, 1);
        chk("clip_mixed", {8'h00, clip_cnt}, 16'h0003);
        sample_chk("unity_x2", 16'h1000, 16'h1000, 16'h2000, 1);

        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
        chk("clr_alone", {8'h00, clip_cnt}, 16'h0000);

        for (int k = 0; k < 300; k++) pulse(16'h7000, 16'h7000);
        chk("clip_sat", {8'h00, clip_cnt}, 16'h00FF);

        // clear lands on the same edge as a clipping output
        left = 16'h9000; right = 16'h9000; sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
        tick();
        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
        chk("clr_coinc_strobe", {15'b0, sample_out}, 16'h0001);
        chk("clr_coinc", {8'h00, clip_cnt}, 16'h0001);
        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
        chk("clr_alone2", {8'h00, clip_cnt}, 16'h0000);

        // async reset with a sample in flight
        sample_chk("pre_rst", 16'h7000, 16'h7000, 16'h7FFF, 1);
        left = 16'h7000; right = 16'h7000; sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_snd", snd, 16'h0000);
        chk("arst_strobe", {15'b0, sample_out}, 16'h0000);
        chk("arst_clip", {8'h00, clip_cnt}, 16'h0000);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sample_out) seen = 1'b1;
        end
        chk("arst_no_ghost", {15'b0, seen}, 16'h0000);
        sample_chk("post_rst", 16'h1000, 16'h1000, 16'h0000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
